// File: rtl/dz_mdm_scan_if.sv
// Modem-status scanner bus: synchronized CO/RI inputs, scan controls and the
// single-entry change-event register seen by the CPU.
interface dz_mdm_scan_if;
    logic [15:0] msr;
    logic        scanEN;
    logic        intEN;
    logic        ackCHG;
    logic        chgVALID;
    logic [2:0]  chgLINE;
    logic        chgCO;
    logic        chgRI;
    logic        chgIRQ;
    logic [2:0]  scanPTR;

    modport master (
        output msr, scanEN, intEN, ackCHG,
        input  chgVALID, chgLINE, chgCO, chgRI, chgIRQ, scanPTR
    );

    modport slave (
        input  msr, scanEN, intEN, ackCHG,
        output chgVALID, chgLINE, chgCO, chgRI, chgIRQ, scanPTR
    );
endinterface

// File: rtl/dz_mdm_scan.sv
// Round-robin modem-status scanner: visits one line every SCANDIV clocks and
// latches the first CO/RI difference against the last reported value.
module dz_mdm_scan #(
    parameter int unsigned SCANDIV = 16
) (
    input  logic         clk,
    input  logic         rst,
    dz_mdm_scan_if.slave bus
);
    localparam int unsigned   TW        = (SCANDIV > 1) ? $clog2(SCANDIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCANDIV - 1);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t        state_q, state_d;
    logic [15:0]   ref_q, ref_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    ptr_q, ptr_d;
    logic          valid_q, valid_d;
    logic [2:0]    line_q, line_d;
    logic          co_q, co_d;
    logic          ri_q, ri_d;
    logic          irq_q, irq_d;

    logic          cur_co, cur_ri, changed, tick_end;

    // CO of line n lives at bit 8+n, RI at bit n.
    assign cur_co   = bus.msr[{1'b1, ptr_q}];
    assign cur_ri   = bus.msr[{1'b0, ptr_q}];
    assign changed  = (cur_co != ref_q[{1'b1, ptr_q}]) || (cur_ri != ref_q[{1'b0, ptr_q}]);
    assign tick_end = (tick_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        tick_d  = tick_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        line_d  = line_q;
        co_d    = co_q;
        ri_d    = ri_q;
        irq_d   = valid_q & bus.intEN;

        // Disable wins over ack and detection; ref tracks msr so re-enable is quiet.
        if (!bus.scanEN) begin
            state_d = IDLE;
            ref_d   = bus.msr;
            tick_d  = '0;
            ptr_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SCAN;
                    ref_d   = bus.msr;
                    tick_d  = '0;
                    ptr_d   = '0;
                end
                SCAN: begin
                    if (tick_end) begin
                        tick_d = '0;
                        if (changed) begin
                            line_d                = ptr_q;
                            co_d                  = cur_co;
                            ri_d                  = cur_ri;
                            ref_d[{1'b1, ptr_q}]  = cur_co;
                            ref_d[{1'b0, ptr_q}]  = cur_ri;
                            valid_d               = 1'b1;
                            state_d               = HOLD;
                        end else begin
                            ptr_d = ptr_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.ackCHG) begin
                        valid_d = 1'b0;
                        ptr_d   = ptr_q + 3'd1;
                        tick_d  = '0;
                        state_d = SCAN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ref_q   <= '0;
            tick_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            line_q  <= '0;
            co_q    <= 1'b0;
            ri_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            tick_q  <= tick_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            line_q  <= line_d;
            co_q    <= co_d;
            ri_q    <= ri_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.chgVALID = valid_q;
    assign bus.chgLINE  = line_q;
    assign bus.chgCO    = co_q;
    assign bus.chgRI    = ri_q;
    assign bus.chgIRQ   = irq_q;
    assign bus.scanPTR  = ptr_q;
endmodule

// File: tb/tb_dz_mdm_scan.sv
// Self-checking bench for dz_mdm_scan: vector table, directed corner cases and
// randomized traffic against a countdown-based reference model.
module tb_dz_mdm_scan;
    localparam int unsigned SCANDIV = 16;

    logic clk;
    logic rst;
    dz_mdm_scan_if bus ();

    dz_mdm_scan #(.SCANDIV(SCANDIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: a per-line sample countdown and a table of last-reported values.
    bit          m_on, m_hold, m_valid, m_co, m_ri, m_irq;
    int unsigned m_ptr, m_evline, m_wait;
    logic [15:0] m_ref;

    typedef struct {
        logic [15:0] msr;
        int unsigned line;
        logic        co;
        logic        ri;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_hold = 0; m_valid = 0; m_co = 0; m_ri = 0; m_irq = 0;
        m_ptr = 0; m_evline = 0; m_wait = SCANDIV; m_ref = '0;
    endtask

    task automatic model_step();
        bit nirq;
        logic co, ri;
        nirq = m_valid & bus.intEN;
        if (!rst) begin
            model_reset();
            return;
        end
        if (!bus.scanEN) begin
            m_on = 0; m_hold = 0; m_valid = 0; m_ptr = 0; m_wait = SCANDIV; m_ref = bus.msr;
        end else if (!m_on) begin
            m_on = 1; m_ptr = 0; m_wait = SCANDIV; m_ref = bus.msr;
        end else if (m_hold) begin
            if (bus.ackCHG) begin
                m_hold = 0; m_valid = 0; m_ptr = (m_ptr + 1) % 8; m_wait = SCANDIV;
            end
        end else begin
            m_wait--;
            if (m_wait == 0) begin
                m_wait = SCANDIV;
                co = bus.msr[8 + m_ptr];
                ri = bus.msr[m_ptr];
                if (co != m_ref[8 + m_ptr] || ri != m_ref[m_ptr]) begin
                    m_evline = m_ptr; m_co = co; m_ri = ri;
                    m_ref[8 + m_ptr] = co; m_ref[m_ptr] = ri;
                    m_valid = 1; m_hold = 1;
                end else begin
                    m_ptr = (m_ptr + 1) % 8;
                end
            end
        end
        m_irq = nirq;
    endtask

    function automatic logic [9:0] dut_outs();
        return {bus.chgVALID, bus.chgLINE, bus.chgCO, bus.chgRI, bus.chgIRQ, bus.scanPTR};
    endfunction

    // One clock: advance the model on the inputs in force, then compare after the edge.
    task automatic cyc();
        logic [9:0] exp;
        model_step();
        @(posedge clk);
        #1;
        exp = {m_valid, m_evline[2:0], m_co, m_ri, m_irq, m_ptr[2:0]};
        if (m_on == 0 && m_valid == 0) exp[8:6] = bus.chgLINE;
        if (m_valid == 0) exp[5:4] = {bus.chgCO, bus.chgRI};
        chk("cycle_outputs", 32'(dut_outs()), 32'(exp));
    endtask

    task automatic wait_valid(input int unsigned budget, input string name);
        int unsigned n = 0;
        while (bus.chgVALID !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        n_checks++;
        if (bus.chgVALID !== 1'b1) begin
            n_errors++;
            $display("FAIL %s: chgVALID=%b after %0d cycles, required 1", name, bus.chgVALID, n);
        end
    endtask

    task automatic ack();
        bus.ackCHG = 1'b1;
        cyc();
        bus.ackCHG = 1'b0;
    endtask

    task automatic restart_scan();
        bus.scanEN = 1'b0;
        bus.msr    = '0;
        cyc();
        bus.scanEN = 1'b1;
        cyc();
    endtask

    initial begin
        bit          seen;
        int unsigned n;
        logic [15:0] t;

        vecs[0] = '{16'h2000, 5, 1'b1, 1'b0};
        vecs[1] = '{16'h0001, 0, 1'b0, 1'b1};
        vecs[2] = '{16'h8000, 7, 1'b1, 1'b0};
        vecs[3] = '{16'h0404, 2, 1'b1, 1'b1};
        vecs[4] = '{16'h0300, 0, 1'b1, 1'b0};

        rst = 1'b0;
        bus.msr = '0; bus.scanEN = 1'b0; bus.intEN = 1'b0; bus.ackCHG = 1'b0;
        model_reset();
        repeat (3) cyc();
        chk("reset_state", 32'(dut_outs()), 32'h0);
        rst = 1'b1;
        cyc();

        // Idle line set: scan advances one line per SCANDIV clocks, no events.
        bus.scanEN = 1'b1;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            seen |= bus.chgVALID;
        end
        chk("quiet_no_event", 32'(seen), 32'h0);
        chk("quiet_scanptr", 32'(bus.scanPTR), 32'h4);

        for (int i = 0; i < 5; i++) begin
            restart_scan();
            bus.msr = vecs[i].msr;
            wait_valid(8 * SCANDIV + 16, "vec_wait");
            chk("vec_line", 32'(bus.chgLINE), 32'(vecs[i].line));
            chk("vec_co_ri", 32'({bus.chgCO, bus.chgRI}), 32'({vecs[i].co, vecs[i].ri}));
            repeat (5) cyc();
            chk("vec_hold_ptr", 32'(bus.scanPTR), 32'(vecs[i].line));
            ack();
            chk("vec_ack_ptr", 32'({bus.chgVALID, bus.scanPTR}), 32'((vecs[i].line + 1) % 8));
        end

        // Two pending lines seen from line 3: line 7 first, then line 0.
        restart_scan();
        n = 0;
        while (bus.scanPTR != 3'd3 && n < 100) begin
            cyc();
            n++;
        end
        chk("reach_line3", 32'(bus.scanPTR), 32'h3);
        bus.msr = 16'h0081;
        wait_valid(8 * SCANDIV + 16, "two_first_wait");
        chk("two_first", 32'({bus.chgLINE, bus.chgCO, bus.chgRI}), 32'({3'd7, 1'b0, 1'b1}));
        ack();
        wait_valid(8 * SCANDIV + 16, "two_second_wait");
        chk("two_second", 32'({bus.chgLINE, bus.chgCO, bus.chgRI}), 32'({3'd0, 1'b0, 1'b1}));
        ack();

        // Interrupt gating and one-cycle registration.
        bus.intEN = 1'b0;
        bus.msr = 16'h0091;
        wait_valid(8 * SCANDIV + 16, "irq_wait");
        cyc();
        chk("irq_masked", 32'({bus.chgLINE, bus.chgIRQ}), 32'({3'd4, 1'b0}));
        bus.intEN = 1'b1;
        cyc();
        chk("irq_raised", 32'(bus.chgIRQ), 32'h1);
        ack();
        chk("irq_ack_valid", 32'(bus.chgVALID), 32'h0);
        cyc();
        chk("irq_ack_irq", 32'(bus.chgIRQ), 32'h0);

        // Disable and ack together in HOLD: event dropped, ref resynced.
        bus.msr = 16'h0191;
        wait_valid(8 * SCANDIV + 16, "dis_wait");
        bus.msr = 16'h4191;
        bus.scanEN = 1'b0;
        bus.ackCHG = 1'b1;
        cyc();
        bus.scanEN = 1'b1;
        bus.ackCHG = 1'b0;
        chk("dis_valid", 32'(bus.chgVALID), 32'h0);
        seen = 0;
        for (int i = 0; i < 8 * SCANDIV + 20; i++) begin
            cyc();
            seen |= bus.chgVALID;
        end
        chk("reenable_no_event", 32'(seen), 32'h0);

        // Asynchronous reset in the middle of HOLD clears outputs before any edge.
        bus.msr = 16'h4190;
        wait_valid(8 * SCANDIV + 16, "arst_wait");
        cyc();
        chk("arst_pre_irq", 32'(bus.chgIRQ), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_outputs", 32'(dut_outs()), 32'h0);
        model_reset();
        cyc();
        rst = 1'b1;

        // Randomized traffic: sparse bit flips, random acks, enables and disables.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                t = bus.msr;
                t[$urandom_range(0, 15)] ^= 1'b1;
                bus.msr = t;
            end
            bus.ackCHG = bus.chgVALID ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 29) == 0);
            bus.scanEN = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 49) == 0) bus.intEN = ~bus.intEN;
            cyc();
        end
        bus.ackCHG = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
